// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters and alu_arbiter.
// master: requester side (ops, rsp_ready); slave: arbiter side.
interface alu_arbiter_if #(
   parameter int DW = 32
);
   logic [1:0]    req_valid;
   logic [1:0]    req_ready;
   logic [DW-1:0] req0_Op1;
   logic [DW-1:0] req0_Op2;
   logic [2:0]    req0_S_Op;
   logic [DW-1:0] req1_Op1;
   logic [DW-1:0] req1_Op2;
   logic [2:0]    req1_S_Op;
   logic [1:0]    rsp_valid;
   logic [1:0]    rsp_ready;
   logic [DW-1:0] rsp_R_Op;
   logic          rsp_ZF;
   logic          rsp_DZ;

   modport master (
      output req_valid, req0_Op1, req0_Op2, req0_S_Op,
      output req1_Op1, req1_Op2, req1_S_Op, rsp_ready,
      input  req_ready, rsp_valid, rsp_R_Op, rsp_ZF, rsp_DZ
   );

   modport slave (
      input  req_valid, req0_Op1, req0_Op2, req0_S_Op,
      input  req1_Op1, req1_Op2, req1_S_Op, rsp_ready,
      output req_ready, rsp_valid, rsp_R_Op, rsp_ZF, rsp_DZ
   );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters.
// Ports: clk, rst (sync, active-high); bus (alu_arbiter_if.slave:
// req_valid/ready, req0/1 ops, rsp_valid/ready, rsp_R_Op/ZF/DZ);
// alu_Op1/Op2/S_Op out (registered), alu_R_Op/ZF in; busy out.
// Define ALU_ARB_RR_EN for round-robin; default is fixed priority.
module alu_arbiter #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   alu_arbiter_if.slave  bus,
   output logic [DW-1:0] alu_Op1,
   output logic [DW-1:0] alu_Op2,
   output logic [2:0]    alu_S_Op,
   input  logic [DW-1:0] alu_R_Op,
   input  logic          alu_ZF,
   output logic          busy
);
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_NOP = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [1:0] grant;
   logic [1:0] tie_grant;
   logic       win;
   logic       take;
   logic       id;
   logic       rsp_hs;

`ifdef ALU_ARB_RR_EN
   // ptr holds the last winner; a tie goes to the other one.
   logic ptr;

   always_ff @(posedge clk) begin
      if (rst)
         ptr <= 1'b1;
      else if (take)
         ptr <= win;
   end

   assign tie_grant = ptr ? 2'b01 : 2'b10;
`else
   assign tie_grant = 2'b01;
`endif

   always_comb begin
      grant = 2'b00;
      unique case (1'b1)
         (bus.req_valid == 2'b11): grant = tie_grant;
         (bus.req_valid == 2'b01): grant = 2'b01;
         (bus.req_valid == 2'b10): grant = 2'b10;
         default:                  grant = 2'b00;
      endcase
   end

   assign win    = grant[1];
   assign take   = (state == IDLE) && (grant != 2'b00);
   assign rsp_hs = (state == RESP) && bus.rsp_ready[id];

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (take) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = 2'b00;
      bus.rsp_valid = 2'b00;
      busy          = (state != IDLE);
      if (state == IDLE)
         bus.req_ready = grant;
      if (state == RESP)
         bus.rsp_valid = {id, ~id};
   end

   // ALU input and result registers; the ALU inputs are
   // deliberately left holding the last op when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_Op1      <= '0;
         alu_Op2      <= '0;
         alu_S_Op     <= OP_NOP;
         id           <= 1'b0;
         bus.rsp_R_Op <= '0;
         bus.rsp_ZF   <= 1'b0;
         bus.rsp_DZ   <= 1'b0;
      end else begin
         if (take) begin
            id       <= win;
            alu_Op1  <= win ? bus.req1_Op1  : bus.req0_Op1;
            alu_Op2  <= win ? bus.req1_Op2  : bus.req0_Op2;
            alu_S_Op <= win ? bus.req1_S_Op : bus.req0_S_Op;
         end
         if (state == EXEC) begin
            if (alu_S_Op == OP_DIV && alu_Op2 == '0) begin
               bus.rsp_R_Op <= '1;
               bus.rsp_ZF   <= 1'b0;
               bus.rsp_DZ   <= 1'b1;
            end else begin
               bus.rsp_R_Op <= alu_R_Op;
               bus.rsp_ZF   <= alu_ZF;
               bus.rsp_DZ   <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU.
// Expected tie-break order follows ALU_ARB_RR_EN.
module tb_alu_arbiter;
   localparam int DW = 32;

   logic          clk;
   logic          rst;
   logic [DW-1:0] alu_Op1;
   logic [DW-1:0] alu_Op2;
   logic [2:0]    alu_S_Op;
   logic [DW-1:0] alu_R_Op;
   logic          alu_ZF;
   logic          busy;

   int total;
   int bad;

   alu_arbiter_if #(.DW(DW)) bus ();

   alu_arbiter #(.DW(DW)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .alu_Op1  (alu_Op1),
      .alu_Op2  (alu_Op2),
      .alu_S_Op (alu_S_Op),
      .alu_R_Op (alu_R_Op),
      .alu_ZF   (alu_ZF),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External ALU: DIV by zero yields 0 here, so the
   // arbiter's override is observable.
   always_comb begin
      case (alu_S_Op)
         3'b000:  alu_R_Op = alu_Op1 + alu_Op2;
         3'b001:  alu_R_Op = alu_Op1 - alu_Op2;
         3'b010:  alu_R_Op = alu_Op1 * alu_Op2;
         3'b011:  alu_R_Op = (alu_Op2 == 0) ? '0
                             : alu_Op1 / alu_Op2;
         3'b100:  alu_R_Op = alu_Op1 & alu_Op2;
         3'b101:  alu_R_Op = alu_Op1 | alu_Op2;
         3'b110:  alu_R_Op = {31'd0, alu_Op1 < alu_Op2};
         default: alu_R_Op = alu_Op1;
      endcase
      alu_ZF = (alu_R_Op == '0);
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_ops(input logic w, input logic [31:0] a,
                          input logic [31:0] b, input logic [2:0] s);
      if (w) begin
         bus.req1_Op1  = a;
         bus.req1_Op2  = b;
         bus.req1_S_Op = s;
      end else begin
         bus.req0_Op1  = a;
         bus.req0_Op2  = b;
         bus.req0_S_Op = s;
      end
   endtask

   task automatic do_reset();
      bus.req_valid = 2'b00;
      bus.rsp_ready = 2'b00;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // Presents rv with rsp_ready held high, returns grant,
   // response and accept-to-valid latency (8 = timed out).
   task automatic run_op(input logic [1:0] rv,
                         output logic [1:0] gnt,
                         output logic [1:0] rvld,
                         output logic [31:0] r,
                         output logic zf, output logic dz,
                         output int lat);
      bus.rsp_ready = 2'b11;
      bus.req_valid = rv;
      #1;
      gnt = bus.req_ready;
      step();
      bus.req_valid = 2'b00;
      lat = 1;
      while (bus.rsp_valid == 2'b00 && lat < 8) begin
         step();
         lat++;
      end
      rvld = bus.rsp_valid;
      r    = bus.rsp_R_Op;
      zf   = bus.rsp_ZF;
      dz   = bus.rsp_DZ;
      step();
      bus.rsp_ready = 2'b00;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({busy, bus.rsp_valid, bus.req_ready} !== 5'b0) begin
         bad++;
         $display("FAIL reset_ctl got=%b exp=00000",
                  {busy, bus.rsp_valid, bus.req_ready});
      end
      total++;
      if ({alu_S_Op, alu_Op1, alu_Op2} !== {3'b111, 64'd0}) begin
         bad++;
         $display("FAIL reset_alu got=%h/%h/%h exp=7/0/0",
                  alu_S_Op, alu_Op1, alu_Op2);
      end
      total++;
      if ({bus.rsp_R_Op, bus.rsp_ZF, bus.rsp_DZ} !== 34'd0) begin
         bad++;
         $display("FAIL reset_rsp got=%h exp=0", bus.rsp_R_Op);
      end
   endtask

   task automatic test_add();
      logic [1:0]  g;
      logic [1:0]  v;
      logic [31:0] r;
      logic        z;
      logic        d;
      int          lat;
      set_ops(1'b0, 32'd5, 32'd3, 3'b000);
      run_op(2'b01, g, v, r, z, d, lat);
      total++;
      if (g !== 2'b01) begin
         bad++;
         $display("FAIL add_ready got=%b exp=01", g);
      end
      total++;
      if (lat !== 2) begin
         bad++;
         $display("FAIL add_latency got=%0d exp=2", lat);
      end
      total++;
      if ({v, r, z, d} !== {2'b01, 32'd8, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL add_rsp got=%b/%h/%b/%b exp=01/8/0/0",
                  v, r, z, d);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL add_idle got=%b exp=0", busy);
      end
   endtask

   task automatic test_backpressure();
      set_ops(1'b1, 32'd7, 32'd7, 3'b001);
      bus.rsp_ready = 2'b00;
      bus.req_valid = 2'b10;
      #1;
      total++;
      if (bus.req_ready !== 2'b10) begin
         bad++;
         $display("FAIL bp_ready got=%b exp=10", bus.req_ready);
      end
      step();
      bus.req_valid = 2'b01;
      #1;
      total++;
      if (bus.req_ready !== 2'b00) begin
         bad++;
         $display("FAIL bp_busy_ready got=%b exp=00",
                  bus.req_ready);
      end
      bus.req_valid = 2'b00;
      step();
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({bus.rsp_valid, bus.rsp_R_Op, bus.rsp_ZF}
             !== {2'b10, 32'd0, 1'b1}) begin
            bad++;
            $display("FAIL bp_hold%0d got=%b/%h/%b exp=10/0/1",
                     i, bus.rsp_valid, bus.rsp_R_Op, bus.rsp_ZF);
         end
         // the non-granted bit must be ignored
         bus.rsp_ready = (i == 1) ? 2'b01 : 2'b00;
         step();
      end
      bus.rsp_ready = 2'b10;
      #1;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL bp_busy got=%b exp=1", busy);
      end
      step();
      bus.rsp_ready = 2'b00;
      total++;
      if ({busy, bus.rsp_valid} !== 3'b000) begin
         bad++;
         $display("FAIL bp_done got=%b exp=000",
                  {busy, bus.rsp_valid});
      end
   endtask

   task automatic test_div();
      logic [1:0]  g;
      logic [1:0]  v;
      logic [31:0] r;
      logic        z;
      logic        d;
      int          lat;
      set_ops(1'b0, 32'd9, 32'd0, 3'b011);
      run_op(2'b01, g, v, r, z, d, lat);
      total++;
      if ({v, r, z, d} !== {2'b01, 32'hFFFF_FFFF, 1'b0, 1'b1})
      begin
         bad++;
         $display("FAIL div0 got=%b/%h/%b/%b exp=01/ffffffff/0/1",
                  v, r, z, d);
      end
      set_ops(1'b0, 32'd9, 32'd3, 3'b011);
      run_op(2'b01, g, v, r, z, d, lat);
      total++;
      if ({v, r, z, d} !== {2'b01, 32'd3, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL div got=%b/%h/%b/%b exp=01/3/0/0",
                  v, r, z, d);
      end
   endtask

   task automatic test_arbitration();
      logic [1:0]  g;
      logic [1:0]  v;
      logic [31:0] r;
      logic        z;
      logic        d;
      int          lat;
      logic [1:0]  exp_g [4];
`ifdef ALU_ARB_RR_EN
      exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
      exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
      do_reset();
      set_ops(1'b0, 32'd1, 32'd1, 3'b001);
      set_ops(1'b1, 32'd1, 32'd1, 3'b001);
      for (int i = 0; i < 4; i++) begin
         run_op(2'b11, g, v, r, z, d, lat);
         total++;
         if (g !== exp_g[i]) begin
            bad++;
            $display("FAIL arb_grant%0d got=%b exp=%b",
                     i, g, exp_g[i]);
         end
         total++;
         if ({v, r, z} !== {exp_g[i], 32'd0, 1'b1}) begin
            bad++;
            $display("FAIL arb_rsp%0d got=%b/%h/%b exp=%b/0/1",
                     i, v, r, z, exp_g[i]);
         end
      end
   endtask

   task automatic test_reset_mid_op();
      logic [1:0]  g;
      logic [1:0]  v;
      logic [31:0] r;
      logic        z;
      logic        d;
      int          lat;
      set_ops(1'b1, 32'd4, 32'd2, 3'b000);
      bus.rsp_ready = 2'b00;
      bus.req_valid = 2'b10;
      step();
      bus.req_valid = 2'b00;
      step();
      total++;
      if (bus.rsp_valid !== 2'b10) begin
         bad++;
         $display("FAIL mid_resp got=%b exp=10", bus.rsp_valid);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++;
      if ({busy, bus.rsp_valid} !== 3'b000) begin
         bad++;
         $display("FAIL mid_abort got=%b exp=000",
                  {busy, bus.rsp_valid});
      end
      set_ops(1'b0, 32'd1, 32'd1, 3'b001);
      run_op(2'b11, g, v, r, z, d, lat);
      total++;
      if ({g, v} !== 4'b0101) begin
         bad++;
         $display("FAIL mid_regrant got=%b/%b exp=01/01", g, v);
      end
   endtask

   task automatic test_slt_nop();
      logic [1:0]  g;
      logic [1:0]  v;
      logic [31:0] r;
      logic        z;
      logic        d;
      int          lat;
      set_ops(1'b0, 32'd2, 32'hFFFF_FFFF, 3'b110);
      run_op(2'b01, g, v, r, z, d, lat);
      total++;
      if ({v, r, z} !== {2'b01, 32'd1, 1'b0}) begin
         bad++;
         $display("FAIL slt got=%b/%h/%b exp=01/1/0", v, r, z);
      end
      set_ops(1'b0, 32'hA, 32'd5, 3'b111);
      run_op(2'b01, g, v, r, z, d, lat);
      total++;
      if ({v, r, z} !== {2'b01, 32'hA, 1'b0}) begin
         bad++;
         $display("FAIL nop got=%b/%h/%b exp=01/a/0", v, r, z);
      end
      total++;
      if ({alu_S_Op, alu_Op1, alu_Op2}
          !== {3'b111, 32'hA, 32'd5}) begin
         bad++;
         $display("FAIL alu_keep got=%h/%h/%h exp=7/a/5",
                  alu_S_Op, alu_Op1, alu_Op2);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.req_valid = 2'b00;
      bus.rsp_ready = 2'b00;
      set_ops(1'b0, 32'd0, 32'd0, 3'b111);
      set_ops(1'b1, 32'd0, 32'd0, 3'b111);
      test_reset();
      test_add();
      test_backpressure();
      test_div();
      test_arbitration();
      test_reset_mid_op();
      test_slt_nop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
